// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the fetch/next-PC sequencer: branch types, FSM states
// and the instruction word step.
package pc_sequencer_pkg;

  localparam int unsigned WORD_STEP = 4;

  typedef enum logic [2:0] {
    BR_SEQ = 3'b000,
    BR_J   = 3'b001,
    BR_BEQ = 3'b010,
    BR_BNE = 3'b011,
    BR_BLT = 3'b100,
    BR_BGE = 3'b101,
    BR_JR  = 3'b110
  } br_type_e;

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_e;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational branch target adder and next-PC selection.
// Encoding 3'b111 is reserved and falls through to sequential.
module pc_target_calc
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned OFFSET_W = 8
) (
  input  logic [ADDR_W-1:0]   pc,
  input  logic [2:0]          br_type,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                zero,
  input  logic                neg,
  input  logic [ADDR_W-1:0]   jr_target,
  output logic [ADDR_W-1:0]   next_pc
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_STEP - 1);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] target;

  assign pc_plus4 = pc + ADDR_W'(WORD_STEP);
  assign off_ext  = ADDR_W'(signed'(offset));
  // Word offset; the sum wraps modulo 2^ADDR_W by design.
  assign target   = pc_plus4 + (off_ext << 2);

  always_comb begin
    next_pc = pc_plus4;
    case (br_type_e'(br_type))
      BR_J:    next_pc = target;
      BR_BEQ:  if (zero) next_pc = target;
      BR_BNE:  if (!zero) next_pc = target;
      BR_BLT:  if (neg) next_pc = target;
      BR_BGE:  if (!neg) next_pc = target;
      BR_JR:   next_pc = jr_target & ALIGN_MASK;
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: holds the PC and fetched instruction, stalls on
// memory busywait and counts retired instructions.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       OFFSET_W = 8,
  parameter int unsigned       CNT_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [INSTR_W-1:0]  IMEM_INSTR,
  input  logic                IMEM_BUSYWAIT,
  input  logic                DMEM_BUSYWAIT,
  input  logic [2:0]          BR_TYPE,
  input  logic [OFFSET_W-1:0] OFFSET,
  input  logic                ZERO,
  input  logic                NEG,
  input  logic [ADDR_W-1:0]   JR_TARGET,
  output logic [ADDR_W-1:0]   PC,
  output logic [INSTR_W-1:0]  INSTRUCTION,
  output logic                INSTR_VALID,
  output logic [CNT_W-1:0]    RETIRED
);

  state_e            state;
  logic [ADDR_W-1:0] next_pc;

  pc_target_calc #(
    .ADDR_W  (ADDR_W),
    .OFFSET_W(OFFSET_W)
  ) u_target_calc (
    .pc       (PC),
    .br_type  (BR_TYPE),
    .offset   (OFFSET),
    .zero     (ZERO),
    .neg      (NEG),
    .jr_target(JR_TARGET),
    .next_pc  (next_pc)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= S_FETCH;
      PC          <= RESET_PC;
      INSTRUCTION <= '0;
      INSTR_VALID <= 1'b0;
      RETIRED     <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!IMEM_BUSYWAIT) begin
            INSTRUCTION <= IMEM_INSTR;
            INSTR_VALID <= 1'b1;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Branch inputs are only meaningful on the exit edge.
          if (!DMEM_BUSYWAIT) begin
            PC          <= next_pc;
            RETIRED     <= RETIRED + CNT_W'(1);
            INSTR_VALID <= 1'b0;
            state       <= S_FETCH;
          end
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a 32-bit instance for the main flows and an
// 8-bit / 2-bit-counter instance for address and counter wrap.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, RESET2;
  logic [31:0] imem_instr;
  logic        imem_busywait, dmem_busywait;
  logic [2:0]  br_type;
  logic [7:0]  offset;
  logic        zero, neg;
  logic [31:0] jr_target;

  logic [31:0] pc, instruction;
  logic        instr_valid;
  logic [15:0] retired;

  logic [7:0]  pc2;
  logic [31:0] instruction2;
  logic        instr_valid2;
  logic [1:0]  retired2;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [15:0] ret;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] model_pc;
  logic [15:0] model_ret;

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IMEM_INSTR   (imem_instr),
    .IMEM_BUSYWAIT(imem_busywait),
    .DMEM_BUSYWAIT(dmem_busywait),
    .BR_TYPE      (br_type),
    .OFFSET       (offset),
    .ZERO         (zero),
    .NEG          (neg),
    .JR_TARGET    (jr_target),
    .PC           (pc),
    .INSTRUCTION  (instruction),
    .INSTR_VALID  (instr_valid),
    .RETIRED      (retired)
  );

  pc_sequencer #(
    .ADDR_W  (8),
    .CNT_W   (2),
    .RESET_PC(8'hFC)
  ) dut_small (
    .CLK          (CLK),
    .RESET        (RESET2),
    .IMEM_INSTR   (imem_instr),
    .IMEM_BUSYWAIT(imem_busywait),
    .DMEM_BUSYWAIT(dmem_busywait),
    .BR_TYPE      (br_type),
    .OFFSET       (offset),
    .ZERO         (zero),
    .NEG          (neg),
    .JR_TARGET    (jr_target[7:0]),
    .PC           (pc2),
    .INSTRUCTION  (instruction2),
    .INSTR_VALID  (instr_valid2),
    .RETIRED      (retired2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: each rising INSTR_VALID is compared with the next scoreboard entry.
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RESET && instr_valid && !prev_valid) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: issue at pc %0h, expected none", pc);
        end else begin
          e = sb_q.pop_front();
          check("sb_pc", pc, e.pc);
          check("sb_instr", instruction, e.instr);
          check("sb_retired", 32'(retired), 32'(e.ret));
        end
      end
      prev_valid = instr_valid;
    end
  end

  // Called right after a negedge with the DUT in S_FETCH.
  task automatic run_instr(input string tag, input logic [31:0] instr, input int imem_st,
                           input logic [2:0] br, input logic [7:0] off, input logic z,
                           input logic n, input logic [31:0] jr, input int dmem_st,
                           input logic [31:0] exp_next);
    sb_q.push_back('{pc: model_pc, instr: instr, ret: model_ret});
    dmem_busywait = 1'b1;
    br_type = BR_J;
    offset = 8'h55;
    imem_busywait = 1'b1;
    imem_instr = 32'hDEAD_BEEF;
    for (int i = 0; i < imem_st; i++) begin
      @(negedge CLK);
      check({tag, "_fstall_pc"}, pc, model_pc);
      check({tag, "_fstall_valid"}, 32'(instr_valid), 32'd0);
    end
    imem_busywait = 1'b0;
    imem_instr = instr;
    @(negedge CLK);
    check({tag, "_exec_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_exec_pc"}, pc, model_pc);
    imem_busywait = 1'b1;
    imem_instr = 32'h0BAD_0BAD;
    br_type = br;
    offset = off;
    zero = z;
    neg = n;
    jr_target = jr;
    for (int i = 0; i < dmem_st; i++) begin
      @(negedge CLK);
      check({tag, "_estall_instr"}, instruction, instr);
      check({tag, "_estall_pc"}, pc, model_pc);
      check({tag, "_estall_ret"}, 32'(retired), 32'(model_ret));
    end
    dmem_busywait = 1'b0;
    @(negedge CLK);
    model_pc = exp_next;
    model_ret = model_ret + 16'd1;
    check({tag, "_exit_pc"}, pc, exp_next);
    check({tag, "_exit_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_exit_ret"}, 32'(retired), 32'(model_ret));
  endtask

  task automatic pulse_reset();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    @(negedge CLK);
    model_pc = 32'd0;
    model_ret = 16'd0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_pc2 [4];
    logic [1:0] exp_ret2 [4];
    exp_pc2  = '{8'h00, 8'h04, 8'h08, 8'h0C};
    exp_ret2 = '{2'd1, 2'd2, 2'd3, 2'd0};

    RESET = 1'b1;
    RESET2 = 1'b1;
    imem_instr = '0;
    imem_busywait = 1'b0;
    dmem_busywait = 1'b0;
    br_type = BR_SEQ;
    offset = '0;
    zero = 1'b0;
    neg = 1'b0;
    jr_target = '0;
    model_pc = 32'd0;
    model_ret = 16'd0;

    repeat (2) @(negedge CLK);
    check("rst_pc", pc, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    RESET = 1'b0;

    // Straight-line code, no stalls
    run_instr("seq0", 32'h1000_0001, 0, BR_SEQ, 8'h00, 1'b0, 1'b0, 32'h0, 0, 32'd4);
    run_instr("seq1", 32'h1000_0002, 0, BR_SEQ, 8'h00, 1'b0, 1'b0, 32'h0, 0, 32'd8);
    run_instr("seq2", 32'h1000_0003, 0, BR_SEQ, 8'h00, 1'b0, 1'b0, 32'h0, 0, 32'd12);
    check("retired_3", 32'(retired), 32'd3);

    pulse_reset();
    run_instr("istall", 32'h2000_0001, 3, BR_SEQ, 8'h00, 1'b0, 1'b0, 32'h0, 0, 32'd4);
    run_instr("seq4", 32'h2000_0002, 0, BR_SEQ, 8'h00, 1'b0, 1'b0, 32'h0, 0, 32'd8);
    run_instr("beq_t", 32'h2000_0003, 0, BR_BEQ, 8'hFE, 1'b1, 1'b0, 32'h0, 0, 32'd4);
    run_instr("seq4b", 32'h2000_0004, 0, BR_SEQ, 8'h00, 1'b0, 1'b0, 32'h0, 0, 32'd8);
    run_instr("beq_nt", 32'h2000_0005, 0, BR_BEQ, 8'hFE, 1'b0, 1'b0, 32'h0, 0, 32'd12);
    run_instr("seq12", 32'h2000_0006, 0, BR_SEQ, 8'h00, 1'b0, 1'b0, 32'h0, 0, 32'h10);
    run_instr("blt_t", 32'h2000_0007, 0, BR_BLT, 8'h03, 1'b0, 1'b1, 32'h0, 0, 32'h20);
    run_instr("j_back", 32'h2000_0008, 0, BR_J, 8'hFB, 1'b0, 1'b0, 32'h0, 0, 32'h10);
    run_instr("bge_nt", 32'h2000_0009, 0, BR_BGE, 8'h03, 1'b0, 1'b1, 32'h0, 0, 32'h14);
    run_instr("jr", 32'h2000_000A, 0, BR_JR, 8'h00, 1'b0, 1'b0, 32'h43, 2, 32'h40);
    run_instr("rsvd", 32'h2000_000B, 0, 3'b111, 8'h10, 1'b1, 1'b1, 32'h0, 0, 32'h44);
    run_instr("bne_t", 32'h2000_000C, 0, BR_BNE, 8'h01, 1'b0, 1'b0, 32'h0, 0, 32'h4C);
    run_instr("blt_nt", 32'h2000_000D, 1, BR_BLT, 8'h05, 1'b0, 1'b0, 32'h0, 0, 32'h50);
    check("retired_13", 32'(retired), 32'd13);

    // Asynchronous reset in the middle of an S_EXEC stall
    sb_q.push_back('{pc: model_pc, instr: 32'h3000_0001, ret: model_ret});
    imem_busywait = 1'b0;
    imem_instr = 32'h3000_0001;
    @(negedge CLK);
    dmem_busywait = 1'b1;
    imem_busywait = 1'b1;
    repeat (2) @(negedge CLK);
    check("mid_stall_valid", 32'(instr_valid), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    check("arst_pc", pc, 32'd0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_retired", 32'(retired), 32'd0);
    check("arst_instr", instruction, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    model_pc = 32'd0;
    model_ret = 16'd0;
    run_instr("post_rst", 32'h3000_0002, 0, BR_SEQ, 8'h00, 1'b0, 1'b0, 32'h0, 0, 32'd4);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    // 8-bit address / 2-bit counter wrap on the small instance
    RESET = 1'b1;
    check("small_rst_pc", 32'(pc2), 32'hFC);
    check("small_rst_ret", 32'(retired2), 32'd0);
    @(negedge CLK);
    RESET2 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      imem_busywait = 1'b0;
      dmem_busywait = 1'b0;
      br_type = BR_SEQ;
      imem_instr = 32'h4000_0000 + 32'(k);
      @(negedge CLK);
      check("small_exec_valid", 32'(instr_valid2), 32'd1);
      check("small_exec_instr", instruction2, 32'h4000_0000 + 32'(k));
      @(negedge CLK);
      check("small_wrap_pc", 32'(pc2), 32'(exp_pc2[k]));
      check("small_wrap_ret", 32'(retired2), 32'(exp_ret2[k]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised fetch/next-PC sequencer for the processor, generalising the program counter, target adder and next-PC selection into one registered block with an explicit fetch/execute state machine. It holds the fetched instruction stable while the datapath executes, and stalls on instruction- or data-memory busywait. It adds signed-less-than branches and a register-indirect jump, and keeps a retired-instruction counter. It sits between the instruction cache, the control unit and the ALU flags.

## Interface
- ADDR_W, 32, PC and target width
- INSTR_W, 32, instruction width
- OFFSET_W, 8, signed word-offset width from the instruction
- CNT_W, 16, retired-instruction counter width
- RESET_PC, 0, PC value after reset
- CLK  in  1  single clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- IMEM_INSTR  in  INSTR_W  instruction word from instruction memory
- IMEM_BUSYWAIT  in  1  instruction memory not ready
- DMEM_BUSYWAIT  in  1  data memory not ready
- BR_TYPE  in  3  000 seq, 001 j, 010 beq, 011 bne, 100 blt, 101 bge, 110 jr, 111 reserved (seq)
- OFFSET  in  OFFSET_W  signed word offset
- ZERO  in  1  ALU result zero
- NEG  in  1  ALU result sign bit
- JR_TARGET  in  ADDR_W  register-sourced target for jr
- PC  out  ADDR_W  current fetch address
- INSTRUCTION  out  INSTR_W  held instruction, valid while INSTR_VALID
- INSTR_VALID  out  1  high in S_EXEC
- RETIRED  out  CNT_W  count of completed instructions

## Operation
- States: S_FETCH, S_EXEC.
- S_FETCH: PC drives instruction memory. If IMEM_BUSYWAIT=1, stay. If 0, latch IMEM_INSTR into INSTRUCTION, go S_EXEC.
- S_EXEC: INSTR_VALID=1; control decodes INSTRUCTION and drives BR_TYPE, OFFSET, ZERO, NEG, JR_TARGET. If DMEM_BUSYWAIT=1, stay; PC, INSTRUCTION and RETIRED are held. If 0: PC <= next_pc, RETIRED <= RETIRED+1, go S_FETCH.
- next_pc:
  - seq = PC+4
  - j = target
  - beq: target if ZERO, else PC+4
  - bne: target if !ZERO, else PC+4
  - blt: target if NEG, else PC+4
  - bge: target if !NEG, else PC+4
  - jr = {JR_TARGET[ADDR_W-1:2], 2'b00}
  - 111 = PC+4
- target = (PC+4) + (sign_extend(OFFSET) << 2), computed at ADDR_W bits, modulo 2^ADDR_W. Wrap-around is legal and unflagged.
- IMEM_BUSYWAIT is ignored in S_EXEC; DMEM_BUSYWAIT is ignored in S_FETCH.
- RETIRED wraps from all-ones to 0.

## Timing
- Reset (asynchronous, any state, including mid-stall): PC=RESET_PC, INSTRUCTION=0, INSTR_VALID=0, RETIRED=0, state S_FETCH.
- First fetch begins in the first cycle after RESET deasserts.
- Minimum two cycles per instruction: one S_FETCH, one S_EXEC. Each busywait-high cycle adds one cycle.
- INSTR_VALID rises on the edge that samples IMEM_BUSYWAIT=0 in S_FETCH. It falls on the edge that samples DMEM_BUSYWAIT=0 in S_EXEC.
- All outputs are registered. next_pc is combinational from inputs sampled at the S_EXEC exit edge. Branch inputs are don't-care in S_FETCH.

## Structure
- Shared package holds:
  - br_type encodings (BR_SEQ, BR_J, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_JR)
  - state encoding
  - word-step constant 4
- One sub-module, pc_target_calc: combinational sign-extend, shift and add, plus the next_pc mux.
- The FSM and registers stay in the top level.

## Test plan
- Reset then straight-line code, busywaits tied 0:
  - PC sequence 0, 4, 8, 12, each held two cycles.
  - RETIRED = 3 after three S_EXEC exits.
- IMEM_BUSYWAIT high 3 cycles in first fetch: INSTR_VALID rises on the 4th edge, PC stays 0 throughout.
- beq at PC=8:
  - OFFSET=0xFE, ZERO=1 -> next PC = 12 - 8 = 4.
  - Same with ZERO=0 -> 12.
- blt at PC=0x10, OFFSET=0x03:
  - NEG=1 -> next PC = 0x20.
  - bge with NEG=1 -> 0x14.
- jr with JR_TARGET=0x43 and DMEM_BUSYWAIT high 2 cycles:
  - INSTRUCTION held for 3 S_EXEC cycles.
  - Next PC = 0x40.
- Wrap and reset:
  - ADDR_W=8, PC=0xFC, seq -> 0x00.
  - RESET pulsed mid-S_EXEC stall -> immediately PC=RESET_PC, INSTR_VALID=0, RETIRED=0.
